fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: word/address widths, opcode field, fetch FSM states, buffer entry.
// Pure declarations; no latency and no flow control of its own.
package cpu_pkg;
  localparam int INSTR_W    = 16;
  localparam int ADDR_W     = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer: a push shows up on head one cycle later, and a pop exposes the next entry one cycle later.
// Push is ignored when full and pop when empty; flush empties it and takes priority over both.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  localparam logic [1:0] FULL = 2'(DEPTH);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && (count != FULL);
  assign pop_ok  = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; with one entry the new word replaces the popped head.
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = (count != 2'd0) ? slot0 : '0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read at a time, responses buffered two deep; instr_valid rises one cycle after mem_ack.
// Stops requesting while the buffer is full; a redirect flushes the buffer and drops any in-flight response.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [2:0]         opcode
);
  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [1:0]        count;
  logic [1:0]        count_after;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign target      = redirect_pc & {{(ADDR_W-1){1'b1}}, 1'b0};
  assign pc_inc      = pc + ADDR_W'(2);
  assign push        = (state == BUSY) && mem_ack && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  assign push_entry.instr = mem_rdata;
  assign push_entry.pc    = mem_addr;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign opcode      = head.instr[OPCODE_MSB:OPCODE_LSB];

  // In BUSY the fetch PC always equals mem_addr, so pc_inc is the next request address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (count < DEPTH_C) begin
            state    <= BUSY;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        BUSY: begin
          if (redirect_valid) begin
            pc <= target;
            if (mem_ack) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              state <= FLUSH;
            end
          end else if (mem_ack) begin
            pc <= pc_inc;
            if (count_after < DEPTH_C) begin
              mem_addr <= pc_inc;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // mem_addr stays on the abandoned request until its ack retires it.
          if (redirect_valid) pc <= target;
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect cases, PC wrap and reset mid-request.
// Memory is either zero-latency (ack follows mem_req) or driven cycle by cycle.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [2:0]  opcode;

  logic        auto_ack;
  logic        man_ack;
  logic [15:0] man_rdata;

  int total = 0;
  int bad   = 0;

  // Word stored at address a: opcode field = a[3:1], low bits = a[12:0].
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[3:1], a[12:0]};
  endfunction

  assign mem_ack   = auto_ack ? mem_req : man_ack;
  assign mem_rdata = auto_ack ? mem_word(mem_addr) : man_rdata;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    man_ack = 1'b0;
    man_rdata = 16'h0000;
    step();
    step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_mem_addr got %h want 0000", mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
    total++; if (instr !== 16'h0000) begin bad++; $display("FAIL rst_instr got %h want 0000", instr); end
    total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL rst_instr_pc got %h want 0000", instr_pc); end
    total++; if (opcode !== 3'd0) begin bad++; $display("FAIL rst_opcode got %0d want 0", opcode); end
    rst = 1'b0;
  endtask

  task automatic test_zero_latency();
    logic [15:0] exp_pc [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    logic [2:0]  exp_op [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [15:0] exp_in [4] = '{16'h0000, 16'h2002, 16'h4004, 16'h6006};
    auto_ack = 1'b1;
    instr_ready = 1'b1;
    test_reset();
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL first_req got %b want 1", mem_req); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL first_addr got %h want 0000", mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL first_valid got %b want 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zl_valid[%0d] got %b want 1", i, instr_valid); end
      total++; if (instr_pc !== exp_pc[i]) begin bad++; $display("FAIL zl_pc[%0d] got %h want %h", i, instr_pc, exp_pc[i]); end
      total++; if (opcode !== exp_op[i]) begin bad++; $display("FAIL zl_opcode[%0d] got %0d want %0d", i, opcode, exp_op[i]); end
      total++; if (instr !== exp_in[i]) begin bad++; $display("FAIL zl_instr[%0d] got %h want %h", i, instr, exp_in[i]); end
    end
  endtask

  task automatic test_backpressure();
    auto_ack = 1'b1;
    instr_ready = 1'b0;
    test_reset();
    step();
    step();
    step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full got %b want 0", mem_req); end
    total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL bp_head got %h want 0000", instr_pc); end
    step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_req_hold got %b want 0", mem_req); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (instr_pc !== 16'h0002) begin bad++; $display("FAIL bp_pop_head got %h want 0002", instr_pc); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_pop_valid got %b want 1", instr_valid); end
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL bp_rereq got %b want 1", mem_req); end
    total++; if (mem_addr !== 16'h0004) begin bad++; $display("FAIL bp_rereq_addr got %h want 0004", mem_addr); end
  endtask

  task automatic test_redirect_full();
    auto_ack = 1'b1;
    instr_ready = 1'b0;
    test_reset();
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0801;
    instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got %b want 0", instr_valid); end
    total++; if (instr_pc !== 16'h0000 || instr !== 16'h0000) begin bad++; $display("FAIL rf_empty_out got pc=%h instr=%h want 0000", instr_pc, instr); end
    step();
    total++; if (mem_addr !== 16'h0800 || mem_req !== 1'b1) begin bad++; $display("FAIL rf_addr got req=%b addr=%h want 1/0800", mem_req, mem_addr); end
  endtask

  task automatic test_latency_redirect();
    auto_ack = 1'b0;
    instr_ready = 1'b1;
    test_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    step();
    redirect_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin bad++; $display("FAIL lr_flush_hold got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    man_ack = 1'b1;
    man_rdata = 16'hBEEF;
    step();
    man_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL lr_stale_dropped got %b want 0", instr_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lr_idle_req got %b want 0", mem_req); end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin bad++; $display("FAIL lr_new_addr got req=%b addr=%h want 1/0040", mem_req, mem_addr); end
    man_ack = 1'b1;
    man_rdata = 16'h1234;
    step();
    man_ack = 1'b0;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040) begin bad++; $display("FAIL lr_first_pc got v=%b pc=%h want 1/0040", instr_valid, instr_pc); end
    total++; if (instr !== 16'h1234) begin bad++; $display("FAIL lr_instr got %h want 1234", instr); end
  endtask

  task automatic test_redirect_ack_pop();
    auto_ack = 1'b0;
    instr_ready = 1'b0;
    test_reset();
    step();
    man_ack = 1'b1;
    man_rdata = 16'h2222;
    step();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin bad++; $display("FAIL rap_pre got v=%b pc=%h want 1/0000", instr_valid, instr_pc); end
    total++; if (mem_addr !== 16'h0002) begin bad++; $display("FAIL rap_pre_addr got %h want 0002", mem_addr); end
    man_rdata = 16'h3333;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0123;
    step();
    man_ack = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rap_empty got %b want 0", instr_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rap_idle got %b want 0", mem_req); end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0122) begin bad++; $display("FAIL rap_target got req=%b addr=%h want 1/0122", mem_req, mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rap_no_push got %b want 0", instr_valid); end
  endtask

  task automatic test_wrap_and_reset();
    auto_ack = 1'b1;
    instr_ready = 1'b1;
    test_reset();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (mem_addr !== 16'hFFFE) begin bad++; $display("FAIL wr_addr got %h want fffe", mem_addr); end
    step();
    total++; if (instr_pc !== 16'hFFFE || opcode !== 3'd7) begin bad++; $display("FAIL wr_pc_top got pc=%h op=%0d want fffe/7", instr_pc, opcode); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL wr_wrap_addr got %h want 0000", mem_addr); end
    step();
    total++; if (instr_pc !== 16'h0000 || instr_valid !== 1'b1) begin bad++; $display("FAIL wr_pc_wrap got v=%b pc=%h want 1/0000", instr_valid, instr_pc); end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0F00;
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    total++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin bad++; $display("FAIL wr_rst_mem got req=%b addr=%h want 0/0000", mem_req, mem_addr); end
    total++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000 || opcode !== 3'd0) begin bad++; $display("FAIL wr_rst_out got v=%b i=%h pc=%h op=%0d want all 0", instr_valid, instr, instr_pc, opcode); end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin bad++; $display("FAIL wr_rst_vector got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
  endtask

  initial begin
    rst = 1'b1;
    auto_ack = 1'b0;
    man_ack = 1'b0;
    man_rdata = 16'h0000;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = 1'b0;
    test_zero_latency();
    test_backpressure();
    test_redirect_full();
    test_latency_redirect();
    test_redirect_ack_pop();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
